// File: rtl/spi_master_if.sv
// Host-side request/response bundle between the register logic and spi_master.
interface spi_master_if;
    logic        start;
    logic        rw;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic [7:0]  rdata;

    // Host register logic: issues requests, watches completion.
    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    // SPI engine: consumes requests, reports completion and read data.
    modport slave (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI initiator running one 24-bit ADI-style frame
// ({rw, 2'b00, addr[12:0]} then one data byte, MSB first) per accepted start.
// csb, sclk and sdi come straight from flops so the pins never glitch.
module spi_master #(
    parameter int unsigned HALF_PERIOD = 4,  // clk cycles per sclk half-period, >= 1
    parameter int unsigned CS_GAP      = 4   // clk cycles csb stays high before done, >= 1
) (
    input  logic        clk,
    input  logic        rst,
    spi_master_if.slave host,
    output logic        csb,
    output logic        sclk,
    output logic        sdi,
    input  logic        sdo
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] SCK_HI = 3'd2;
    localparam logic [2:0] SCK_LO = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [2:0] GAP    = 3'd5;

    // The phase timer is loaded with (length - 1) and the phase ends when it reaches zero.
    localparam int unsigned   TW     = 16;
    localparam logic [TW-1:0] H_LOAD = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] G_LOAD = TW'(CS_GAP - 1);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [22:0]   tx_shift;   // bits still to send after the one currently on sdi
    logic [4:0]    bit_cnt;    // index of the bit currently on the wire, 0..23
    logic          rw_q;
    logic [7:0]    rx_shift;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    rdata_q;

    assign host.busy  = busy_q;
    assign host.done  = done_q;
    assign host.rdata = rdata_q;

    // Frame sequencer: phase timing, pin drive, serialisation and read capture.
    // NOTE: every register here uses non-blocking assignment so all flops update
    // together from pre-edge values; a blocking write would leak new values into
    // later statements of the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            tx_shift <= '0;
            bit_cnt  <= '0;
            rw_q     <= 1'b0;
            rx_shift <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            csb      <= 1'b1;
            sclk     <= 1'b0;
            sdi      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != IDLE && timer != '0) begin
                timer <= timer - 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // Accepting in the done cycle too lets a held start chain frames.
                        if (host.start) begin
                            tx_shift <= {2'b00, host.addr, host.rw ? 8'h00 : host.wdata};
                            rw_q     <= host.rw;
                            bit_cnt  <= '0;
                            csb      <= 1'b0;
                            sdi      <= host.rw;
                            busy_q   <= 1'b1;
                            timer    <= H_LOAD;
                            state    <= SETUP;
                        end
                    end
                    SETUP: begin
                        sclk  <= 1'b1;
                        timer <= H_LOAD;
                        state <= SCK_HI;
                    end
                    SCK_LO: begin
                        // sdo is taken at the edge that raises sclk, i.e. the slave's
                        // value after the previous falling edge.
                        sclk <= 1'b1;
                        if (rw_q && bit_cnt >= 5'd16) begin
                            rx_shift <= {rx_shift[6:0], sdo};
                        end
                        timer <= H_LOAD;
                        state <= SCK_HI;
                    end
                    SCK_HI: begin
                        sclk  <= 1'b0;
                        timer <= H_LOAD;
                        if (bit_cnt == 5'd23) begin
                            sdi   <= 1'b0;
                            state <= HOLD;
                        end else begin
                            sdi      <= tx_shift[22];
                            tx_shift <= {tx_shift[21:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                            state    <= SCK_LO;
                        end
                    end
                    HOLD: begin
                        csb   <= 1'b1;
                        timer <= G_LOAD;
                        state <= GAP;
                    end
                    GAP: begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        if (rw_q) begin
                            rdata_q <= rx_shift;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (H=G=4 and H=G=1) share the
// stimulus; a cycle-level reference built from the frame timing rules predicts
// every pin and status signal, and a behavioural slave supplies read data.
module tb_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel = 1'b0;          // 0: H=G=4 instance, 1: H=G=1 instance
    logic        start_s = 1'b0;
    logic        rw_s = 1'b0;
    logic [12:0] addr_s = '0;
    logic [7:0]  wdata_s = '0;
    logic        sdo_s = 1'b0;
    logic        csb4, sclk4, sdi4, csb1, sclk1, sdi1;

    spi_master_if bus4();
    spi_master_if bus1();

    assign bus4.start = start_s & ~sel;
    assign bus4.rw    = rw_s;
    assign bus4.addr  = addr_s;
    assign bus4.wdata = wdata_s;
    assign bus1.start = start_s & sel;
    assign bus1.rw    = rw_s;
    assign bus1.addr  = addr_s;
    assign bus1.wdata = wdata_s;

    spi_master #(.HALF_PERIOD(4), .CS_GAP(4)) dut4 (
        .clk(clk), .rst(rst), .host(bus4),
        .csb(csb4), .sclk(sclk4), .sdi(sdi4), .sdo(sdo_s));
    spi_master #(.HALF_PERIOD(1), .CS_GAP(1)) dut1 (
        .clk(clk), .rst(rst), .host(bus1),
        .csb(csb1), .sclk(sclk1), .sdi(sdi1), .sdo(sdo_s));

    logic       csb_m, sclk_m, sdi_m, busy_m, done_m;
    logic [7:0] rdata_m;
    assign csb_m   = sel ? csb1 : csb4;
    assign sclk_m  = sel ? sclk1 : sclk4;
    assign sdi_m   = sel ? sdi1 : sdi4;
    assign busy_m  = sel ? bus1.busy : bus4.busy;
    assign done_m  = sel ? bus1.done : bus4.done;
    assign rdata_m = sel ? bus1.rdata : bus4.rdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle log of the selected instance, keyed by cycle number.
    logic       csb_log [int];
    logic       sclk_log [int];
    logic       sdi_log [int];
    logic       busy_log [int];
    logic       done_log [int];
    logic [7:0] rdata_log [int];

    int         falls = 0;
    logic [7:0] slave_byte = '0;
    logic       sclk_prev = 1'b0;
    logic       csb_prev = 1'b1;
    logic [7:0] model_rdata [2] = '{8'h00, 8'h00};
    int         n_checks = 0;
    int         n_pass = 0;

    // Logger plus slave: after the 16th falling edge the slave presents its byte MSB first.
    always @(negedge clk) begin
        csb_log[cyc]   = csb_m;
        sclk_log[cyc]  = sclk_m;
        sdi_log[cyc]   = sdi_m;
        busy_log[cyc]  = busy_m;
        done_log[cyc]  = done_m;
        rdata_log[cyc] = rdata_m;
        if (rst || (!csb_m && csb_prev)) begin
            falls = 0;
            sdo_s = 1'b0;
        end else if (!sclk_m && sclk_prev) begin
            falls++;
            if (falls >= 16 && falls < 24) sdo_s = slave_byte[23 - falls];
            else sdo_s = 1'b0;
        end
        sclk_prev = sclk_m;
        csb_prev  = csb_m;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, done never settled");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic string sig_name(input int k);
        case (k)
            0: return "sclk";
            1: return "csb";
            2: return "sdi";
            3: return "busy";
            4: return "done";
            default: return "rdata";
        endcase
    endfunction

    function automatic int cur_h();
        return sel ? 1 : 4;
    endfunction

    task automatic start_frame(input logic r, input logic [12:0] a, input logic [7:0] w,
                               input logic [7:0] sb, output int t0);
        slave_byte = sb;
        rw_s = r; addr_s = a; wdata_s = w; start_s = 1'b1;
        t0 = cyc;
        tick();
        start_s = 1'b0;
        rw_s = 1'($urandom); addr_s = 13'($urandom); wdata_s = 8'($urandom);
    endtask

    // Waits (bounded) for done, checks its cycle, and leaves the log complete up to it.
    task automatic wait_done(input string name, input int t0, output int dcyc);
        int last;
        last = t0 + 1 + 50 * cur_h();
        dcyc = -1;
        while (cyc <= last + 40) begin
            if (done_m === 1'b1) begin
                dcyc = cyc;
                break;
            end
            tick();
        end
        n_checks++;
        if (dcyc !== last) $display("FAIL %s_done_cycle: got %0d, required %0d", name, dcyc - t0, last - t0);
        else n_pass++;
        while (cyc < last) tick();
    endtask

    // Compares every logged cycle of one frame with the timing rules, then decodes the frame.
    task automatic verify_frame(input string name, input int t0, input logic r,
                                input logic [12:0] a, input logic [7:0] w, input logic [7:0] sb);
        int h, last, off, rises, idx;
        int bad [6];
        int first [6];
        logic [7:0] g8 [6];
        logic [7:0] e8 [6];
        logic [7:0] fg [6];
        logic [7:0] fe [6];
        logic [7:0] prev, newr;
        logic [23:0] word, rx;
        h = cur_h();
        idx = sel ? 1 : 0;
        last = t0 + 1 + 50 * h;
        word = {r, 2'b00, a, r ? 8'h00 : w};
        prev = model_rdata[idx];
        newr = r ? sb : prev;
        rises = 0;
        rx = '0;
        for (int k = 0; k < 6; k++) begin bad[k] = 0; first[k] = -1; fg[k] = '0; fe[k] = '0; end
        for (int c = t0 + 1; c <= last; c++) begin
            off = c - (t0 + 1 + h);
            e8[0] = {7'b0, (off >= 0) && (off < 48 * h) && ((off / h) % 2 == 0)};
            e8[1] = {7'b0, c > t0 + 49 * h};
            e8[2] = {7'b0, (c < t0 + 1 + 48 * h) ? word[23 - (c - t0 - 1) / (2 * h)] : 1'b0};
            e8[3] = {7'b0, c < last};
            e8[4] = {7'b0, c == last};
            e8[5] = (c == last) ? newr : prev;
            g8[0] = {7'b0, sclk_log[c]};
            g8[1] = {7'b0, csb_log[c]};
            g8[2] = {7'b0, sdi_log[c]};
            g8[3] = {7'b0, busy_log[c]};
            g8[4] = {7'b0, done_log[c]};
            g8[5] = rdata_log[c];
            for (int k = 0; k < 6; k++) begin
                if (g8[k] !== e8[k]) begin
                    if (bad[k] == 0) begin first[k] = c - t0; fg[k] = g8[k]; fe[k] = e8[k]; end
                    bad[k]++;
                end
            end
            if (sclk_log[c] === 1'b1 && sclk_log[c - 1] === 1'b0) begin
                rises++;
                rx = {rx[22:0], sdi_log[c]};
            end
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (bad[k] !== 0)
                $display("FAIL %s_%s: %0d wrong cycles, first at frame cycle %0d got %0h required %0h",
                         name, sig_name(k), bad[k], first[k], fg[k], fe[k]);
            else n_pass++;
        end
        n_checks++;
        if (rises !== 24) $display("FAIL %s_rise_count: got %0d, required 24", name, rises);
        else n_pass++;
        n_checks++;
        if (rx !== word) $display("FAIL %s_decoded_frame: got %06h, required %06h", name, rx, word);
        else n_pass++;
        model_rdata[idx] = newr;
    endtask

    task automatic do_frame(input string name, input logic r, input logic [12:0] a,
                            input logic [7:0] w, input logic [7:0] sb);
        int t0, d;
        start_frame(r, a, w, sb, t0);
        wait_done(name, t0, d);
        verify_frame(name, t0, r, a, w, sb);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({csb_m, sclk_m, sdi_m, busy_m, done_m} !== 5'b10000)
            $display("FAIL %s_pins: got csb/sclk/sdi/busy/done=%b, required 10000", name,
                     {csb_m, sclk_m, sdi_m, busy_m, done_m});
        else n_pass++;
        n_checks++;
        if (rdata_m !== 8'h00) $display("FAIL %s_rdata: got %02h, required 00", name, rdata_m);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        sel = 1'b0;
        check_reset_outputs("reset4");
        sel = 1'b1;
        #1;
        check_reset_outputs("reset1");
        sel = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        do_frame("write_spec", 1'b0, 13'h0014, 8'hA5, 8'h5A);
    endtask

    task automatic test_read();
        do_frame("read_spec", 1'b1, 13'h0001, 8'h00, 8'h3C);
        do_frame("write_after_read", 1'b0, 13'($urandom), 8'($urandom), 8'hC3);
        n_checks++;
        if (rdata_m !== 8'h3C) $display("FAIL write_keeps_rdata: got %02h, required 3c", rdata_m);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            do_frame("random", 1'($urandom), 13'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        int t0, d1, d2, high;
        logic [12:0] a1, a2;
        logic [7:0] w1, sb2;
        a1 = 13'($urandom); w1 = 8'($urandom); a2 = 13'($urandom); sb2 = 8'($urandom);
        slave_byte = sb2;
        rw_s = 1'b0; addr_s = a1; wdata_s = w1; start_s = 1'b1;
        t0 = cyc;
        tick();
        rw_s = 1'b1; addr_s = a2; wdata_s = 8'($urandom);
        wait_done("b2b_first", t0, d1);
        tick();
        start_s = 1'b0;
        rw_s = 1'($urandom); addr_s = 13'($urandom);
        wait_done("b2b_second", d1, d2);
        verify_frame("b2b_first", t0, 1'b0, a1, w1, 8'h00);
        verify_frame("b2b_second", d1, 1'b1, a2, 8'h00, sb2);
        high = 0;
        for (int c = t0 + 1; c < d1; c++) if (csb_log[c] === 1'b1) high++;
        n_checks++;
        if (high !== 4) $display("FAIL b2b_gap: csb high %0d cycles before done, required 4", high);
        else n_pass++;
        n_checks++;
        if (csb_log[d1 + 1] !== 1'b0) $display("FAIL b2b_refall: csb after done got %b, required 0", csb_log[d1 + 1]);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int t0, d, extra;
        logic [12:0] a;
        logic [7:0] sb;
        a = 13'($urandom); sb = 8'($urandom);
        start_frame(1'b1, a, 8'h00, sb, t0);
        while (cyc < t0 + 50) tick();
        start_s = 1'b1; rw_s = 1'b0; addr_s = 13'($urandom);
        tick();
        start_s = 1'b0;
        while (cyc < t0 + 120) tick();
        start_s = 1'b1; rw_s = 1'b0; addr_s = 13'($urandom);
        tick();
        start_s = 1'b0;
        wait_done("busy_ignore", t0, d);
        verify_frame("busy_ignore", t0, 1'b1, a, 8'h00, sb);
        repeat (60) tick();
        extra = 0;
        for (int c = t0 + 202; c < cyc; c++) if (done_log[c] === 1'b1 || csb_log[c] === 1'b0) extra++;
        n_checks++;
        if (extra !== 0) $display("FAIL busy_ignore_extra: got %0d active cycles after done, required 0", extra);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int t0, dones;
        do_frame("pre_reset_read", 1'b1, 13'($urandom), 8'h00, 8'h96);
        start_frame(1'b0, 13'($urandom), 8'($urandom), 8'h00, t0);
        while (cyc < t0 + 50) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("reset_mid");
        repeat (2) tick();
        rst = 1'b0;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;
        repeat (250) tick();
        dones = 0;
        for (int c = t0 + 1; c < cyc; c++) if (done_log[c] === 1'b1) dones++;
        n_checks++;
        if (dones !== 0) $display("FAIL reset_mid_no_done: got %0d done pulses, required 0", dones);
        else n_pass++;
    endtask

    task automatic test_fast();
        sel = 1'b1;
        tick();
        do_frame("fast_ff", 1'b1, 13'($urandom), 8'($urandom), 8'hFF);
        do_frame("fast_00", 1'b1, 13'($urandom), 8'($urandom), 8'h00);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
        test_fast();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
